// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops words from a show-ahead FIFO and sends each one as an
// asynchronous serial frame on txd. A frame is a start bit, the data bits
// LSB first, and a stop bit. The next word is popped on the last stop cycle,
// so frames follow each other with no idle gap while the FIFO has data.
//
// Parameters:
//   DataWidth - frame payload width (must match the FIFO word width)
//   ClkDiv    - clk cycles per serial bit, >= 2
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   empty - FIFO empty flag; when low, q holds the head word
//   q     - FIFO head word, sampled only on the pop edge
//   ack   - FIFO read strobe (combinational), pops the head word
//   txd   - serial output, idle high
//   busy  - high while a frame is in progress
//
// Build option: define UART_TX_DRAIN_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | no frame in progress, txd high, waiting for data
// START  | start bit (txd low)
// DATA   | data bits, LSB first
// PARITY | even parity of the loaded word (parity build only)
// STOP   | stop bit; next word popped on its last cycle

module uart_tx_drain #(
  parameter int DataWidth = 8,
  parameter int ClkDiv    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty,
  input  logic [DataWidth-1:0] q,
  output logic                 ack,
  output logic                 txd,
  output logic                 busy
);

  generate
    if (ClkDiv < 2) begin : g_bad_clkdiv
      $error("uart_tx_drain: ClkDiv must be >= 2");
    end
  endgenerate

  localparam int BaudW = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
  localparam int CntW  = $clog2(DataWidth) + 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(ClkDiv - 1);
  localparam logic [CntW-1:0]  LastBit = CntW'(DataWidth - 1);

`ifdef UART_TX_DRAIN_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [BaudW-1:0]     baud;
  logic [CntW-1:0]      bitcnt;
  logic [DataWidth-1:0] shreg;
  logic [DataWidth-1:0] shreg_sh;
  logic                 baud_tc;

  assign baud_tc  = (baud == '0);
  assign shreg_sh = shreg >> 1;

  // Pop either from IDLE or on the final stop cycle, which makes
  // back-to-back frames gapless.
  assign ack = !rst && !empty &&
               ((state == IDLE) || ((state == STOP) && baud_tc));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      txd    <= 1'b1;
      busy   <= 1'b0;
      baud   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (ack) begin
      shreg  <= q;
      baud   <= BaudMax;
      bitcnt <= '0;
      state  <= START;
      txd    <= 1'b0;
      busy   <= 1'b1;
`ifdef UART_TX_DRAIN_PARITY_EN
      parity <= ^q;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
        end
        START: begin
          if (baud_tc) begin
            state <= DATA;
            baud  <= BaudMax;
            txd   <= shreg[0];
          end else begin
            baud <= baud - BaudW'(1);
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud   <= BaudMax;
            shreg  <= shreg_sh;
            bitcnt <= bitcnt + CntW'(1);
            if (bitcnt == LastBit) begin
`ifdef UART_TX_DRAIN_PARITY_EN
              state <= PARITY;
              txd   <= parity;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd <= shreg_sh[0];
            end
          end else begin
            baud <= baud - BaudW'(1);
          end
        end
`ifdef UART_TX_DRAIN_PARITY_EN
        PARITY: begin
          if (baud_tc) begin
            state <= STOP;
            baud  <= BaudMax;
            txd   <= 1'b1;
          end else begin
            baud <= baud - BaudW'(1);
          end
        end
`endif
        STOP: begin
          // A non-empty FIFO on the last stop cycle is handled by the
          // ack branch above; reaching here means the FIFO ran dry.
          if (baud_tc) begin
            state <= IDLE;
            busy  <= 1'b0;
            txd   <= 1'b1;
          end else begin
            baud <= baud - BaudW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Testbench for uart_tx_drain: a ClkDiv=4 instance for directed frame
// checks and a ClkDiv=16 instance fed random words and decoded by a
// behavioural UART receiver.
module tb_uart_tx_drain;

  localparam int DW   = 8;
  localparam int CD4  = 4;
  localparam int CD16 = 16;
`ifdef UART_TX_DRAIN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB = DW + 2 + PB;  // bits per frame
  localparam int P4 = FB * CD4;     // frame period of the ClkDiv=4 instance
  localparam int NW = 20;           // words in the random run

  typedef logic [7:0] wq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty4, empty16;
  logic [7:0] q4, q16;
  logic       ack4, txd4, busy4, ack16, txd16, busy16;

  uart_tx_drain #(.DataWidth(DW), .ClkDiv(CD4)) dut4 (
    .clk(clk), .rst(rst), .empty(empty4), .q(q4),
    .ack(ack4), .txd(txd4), .busy(busy4)
  );

  uart_tx_drain #(.DataWidth(DW), .ClkDiv(CD16)) dut16 (
    .clk(clk), .rst(rst), .empty(empty16), .q(q16),
    .ack(ack16), .txd(txd16), .busy(busy16)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   viol4 = 0, viol16 = 0;
  wq_t  fifo4, fifo16, sentq, rxq;
  logic tr_txd[$], tr_busy[$], tr_ack[$];

  bit         rx_en = 1'b0, rx_on = 1'b0;
  int         rx_cnt = 0, rx_ferr = 0, rx_perr = 0;
  logic [7:0] rx_w = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    empty4  = (fifo4.size() == 0);
    q4      = empty4 ? 8'($urandom) : fifo4[0];
    empty16 = (fifo16.size() == 0);
    q16     = empty16 ? 8'($urandom) : fifo16[0];
  endtask

  task automatic clear_log();
    tr_txd.delete();
    tr_busy.delete();
    tr_ack.delete();
  endtask

  // One clock: sample outputs mid-cycle, then apply pops after the edge.
  task automatic cycle();
    logic a4, a16;
    @(negedge clk);
    a4  = ack4;
    a16 = ack16;
    tr_txd.push_back(txd4);
    tr_busy.push_back(busy4);
    tr_ack.push_back(ack4);
    if (a4 && empty4) viol4++;
    if (a16 && empty16) viol16++;
    if (rx_on) begin
      rx_cnt++;
      for (int k = 1; k <= DW; k++)
        if (rx_cnt == k * CD16 + CD16 / 2) rx_w[k-1] = txd16;
      if (PB == 1 && rx_cnt == (DW + 1) * CD16 + CD16 / 2 && txd16 !== ^rx_w) rx_perr++;
      if (rx_cnt == CD16 / 2 && txd16 !== 1'b0) rx_ferr++;
      if (rx_cnt == (DW + 1 + PB) * CD16 + CD16 / 2) begin
        if (txd16 !== 1'b1) rx_ferr++;
        rxq.push_back(rx_w);
        rx_on = 1'b0;
      end
    end else if (rx_en && txd16 === 1'b0) begin
      rx_on  = 1'b1;
      rx_cnt = 0;
    end
    @(posedge clk);
    #1;
    if (a4 && fifo4.size() > 0) void'(fifo4.pop_front());
    if (a16 && fifo16.size() > 0) void'(fifo16.pop_front());
    refresh();
  endtask

  function automatic logic frame_bit(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    if (PB == 1 && k == DW + 1) return ^w;
    return 1'b1;
  endfunction

  function automatic int acks_n();
    int n = 0;
    foreach (tr_ack[i]) if (tr_ack[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int ack_from(input int s);
    for (int i = s; i < tr_ack.size(); i++) if (tr_ack[i] === 1'b1) return i;
    return -1;
  endfunction

  // Frames start one cycle after the ack at log index a, back to back.
  task automatic check_frames(input string tag, input wq_t words, input int a);
    int base;
    logic [31:0] obs;
    for (int j = 0; j < words.size(); j++) begin
      for (int k = 0; k < FB; k++) begin
        base = a + 1 + (j * FB + k) * CD4;
        if (base + CD4 > tr_txd.size()) obs = 'x;
        else begin
          obs = {31'b0, tr_txd[base]};
          for (int m = 1; m < CD4; m++) if (tr_txd[base+m] !== tr_txd[base]) obs = 'x;
        end
        chk($sformatf("%s w%0d bit%0d", tag, j, k), obs, {31'b0, frame_bit(words[j], k)});
      end
    end
  endtask

  initial begin
    wq_t wl;
    int  n, n2;
    refresh();
    repeat (3) cycle();
    rst = 1'b0;

    // reset state
    clear_log();
    cycle();
    chk("reset txd", {31'b0, tr_txd[0]}, 1);
    chk("reset busy", {31'b0, tr_busy[0]}, 0);
    chk("reset ack", {31'b0, tr_ack[0]}, 0);

    // FIFO held empty
    clear_log();
    repeat (200) cycle();
    n = 0; n2 = 0;
    foreach (tr_txd[i]) begin
      if (tr_txd[i] !== 1'b1) n++;
      if (tr_busy[i] !== 1'b0) n2++;
    end
    chk("idle acks", acks_n(), 0);
    chk("idle txd not 1", n, 0);
    chk("idle busy", n2, 0);

    // single word 0xA5
    clear_log();
    fifo4.push_back(8'hA5);
    refresh();
    repeat (P4 + 8) cycle();
    wl = '{8'hA5};
    chk("a5 ack count", acks_n(), 1);
    chk("a5 ack index", ack_from(0), 0);
    check_frames("a5", wl, 0);
    n = 0;
    foreach (tr_busy[i]) if (tr_busy[i] === 1'b1) n++;
    chk("a5 busy cycles", n, P4);
    chk("a5 busy after", {31'b0, tr_busy[P4+1]}, 0);
    chk("a5 txd after", {31'b0, tr_txd[P4+1]}, 1);
    chk("a5 fifo empty", {31'b0, empty4}, 1);

    // back-to-back 0x00, 0xFF, 0x07
    clear_log();
    fifo4.push_back(8'h00);
    fifo4.push_back(8'hFF);
    fifo4.push_back(8'h07);
    refresh();
    repeat (3 * P4 + 8) cycle();
    wl = '{8'h00, 8'hFF, 8'h07};
    chk("b2b ack count", acks_n(), 3);
    chk("b2b ack2 index", ack_from(1), P4);
    chk("b2b ack3 index", ack_from(P4 + 1), 2 * P4);
    check_frames("b2b", wl, 0);
    n = 0;
    foreach (tr_busy[i]) if (tr_busy[i] === 1'b1) n++;
    chk("b2b busy cycles", n, 3 * P4);

    // reset 13 cycles into a 0x3C frame with 0x5A queued
    clear_log();
    fifo4.push_back(8'h3C);
    fifo4.push_back(8'h5A);
    refresh();
    repeat (14) cycle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst ack at edge", {31'b0, tr_ack[14]}, 0);
    chk("rst ack held", {31'b0, tr_ack[15]}, 0);
    chk("rst txd after", {31'b0, tr_txd[15]}, 1);
    chk("rst busy after", {31'b0, tr_busy[15]}, 0);
    repeat (P4 + 8) cycle();
    chk("rst ack count", acks_n(), 2);
    chk("rst requeue ack", ack_from(1), 16);
    wl = '{8'h5A};
    check_frames("rst", wl, 16);
    chk("rst fifo empty", {31'b0, empty4}, 1);

    // random end-to-end on the ClkDiv=16 instance
    sentq.delete();
    rxq.delete();
    rx_on = 1'b0;
    rx_en = 1'b1;
    n = 0;
    for (int c = 0; c < 20000 && rxq.size() < NW; c++) begin
      if (n < NW && $urandom_range(0, 99) < 3) begin
        wl = '{8'($urandom)};
        fifo16.push_back(wl[0]);
        sentq.push_back(wl[0]);
        n++;
        refresh();
      end
      cycle();
    end
    repeat (2 * CD16) cycle();
    chk("rand word count", rxq.size(), NW);
    for (int i = 0; i < NW; i++)
      chk($sformatf("rand word %0d", i), (i < rxq.size()) ? {24'b0, rxq[i]} : 'x, {24'b0, sentq[i]});
    chk("rand framing", rx_ferr, 0);
    chk("rand parity", rx_perr, 0);
    chk("rand busy end", {31'b0, busy16}, 0);
    chk("rand txd end", {31'b0, txd16}, 1);
    chk("ack while empty 4", viol4, 0);
    chk("ack while empty 16", viol16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Downstream consumer of the show-ahead single-clock FIFO.
- Pops words from the FIFO's show-ahead output (`q`/`empty`, with `ack` as the read strobe) and serializes each one as an asynchronous serial frame on `txd`: start bit, data bits LSB first, stop bit.
- Back-to-back frames are sent gaplessly while the FIFO stays non-empty.
- Sits between the FIFO and the board's TX pin.

Parameters:
- DataWidth, 8: frame payload width; must match the FIFO's DataWidth.
- ClkDiv, 16: clock cycles per serial bit. Legal range ≥ 2; checked by elaboration assertion.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- empty  in  1  FIFO empty flag; when 0, q holds the head word (show-ahead).
- q  in  DataWidth  FIFO head word.
- ack  out  1  read strobe to FIFO; pops the head at the rising edge where it is 1.
- txd  out  1  serial output, idle high.
- busy  out  1  1 while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, txd=1, busy=0, bit counter and baud counter cleared. `ack` is forced 0 while rst=1, combinationally.
- Reset mid-frame: frame aborted, no further pop. txd=1 from the cycle after the reset edge. A stop bit is not completed.
- State machine: IDLE, START, DATA, [PARITY], STOP.
- `ack` is combinational: ack = !rst & !empty & (state==IDLE | (state==STOP & baud==0)). It never asserts when empty=1.
- Load on ack=1 at an edge:
  - shift register <= q, baud <= ClkDiv-1, bitcnt <= 0, state <= START.
  - txd is registered: START drives txd=0 from the following cycle.
- Baud counter: down-counter, reloads to ClkDiv-1 at every bit boundary. Each bit occupies exactly ClkDiv cycles.
- START, baud==0: go to DATA.
- DATA:
  - txd = shreg[0].
  - At baud==0: shift right, bitcnt++. After bit DataWidth-1, go to PARITY if enabled, else STOP.
  - bitcnt is $clog2(DataWidth)+1 bits wide; no wrap.
- STOP:
  - txd=1 for ClkDiv cycles.
  - At baud==0: if !empty, ack and load as above (gapless next START); else go to IDLE.
- Frame period (no parity): exactly (DataWidth+2)*ClkDiv cycles, back-to-back, with no idle cycle between frames.
- First-frame latency: first START cycle begins 1 cycle after the IDLE ack edge.
- Empty→non-empty while busy: ignored until the last STOP cycle.
- IDLE: txd=1, busy=0.
- `q` is sampled only at the ack edge. Changes to q at other times have no effect.

Optional Feature:
- Macro: UART_TX_DRAIN_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, ClkDiv cycles long.
  - txd = XOR of the loaded word (even parity), computed at load time and stored in a register.
  - Frame period becomes (DataWidth+3)*ClkDiv.
- Undefined: no PARITY state, no parity register. Frame is start + data + stop.

Test Plan:
- ClkDiv=4, one word 0xA5 pushed into the FIFO:
  - single ack pulse;
  - txd per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1;
  - busy high for 40 cycles, then txd=1, ack=0, empty=1.
- ClkDiv=4, words 0x00 then 0xFF queued:
  - second ack coincides with the last STOP cycle of frame 1;
  - the two frames are contiguous over 80 cycles: 0, eight 0s, 1, 0, eight 1s, 1.
- FIFO held empty for 200 cycles after reset: ack never 1, txd constantly 1, busy 0.
- ClkDiv=4, rst asserted 13 cycles into a 0x3C frame with a second word queued:
  - txd=1 and busy=0 the cycle after the reset edge;
  - no ack during reset;
  - after release, the queued word is popped and sent in full.
- With UART_TX_DRAIN_PARITY_EN, ClkDiv=4:
  - 0xA5 → parity bit 0; 0x07 → parity bit 1;
  - frame is 44 cycles; back-to-back period is 44.
- Random end-to-end:
  - lfsr-driven pushes into the FIFO, ClkDiv=16;
  - a bench UART receiver model recovers every word in order, with no loss or duplication;
  - ack is never 1 while empty=1.
